// File: rtl/conv_tile_ctrl.sv
// conv_tile_ctrl: weight-preload / ifmap-stream tile sequencer with overlapped fetch and pipeline drain.
// Optional feature macro: CONV_CTRL_PERF_EN adds the perf_stall counter port.
module conv_tile_ctrl #(
    parameter int CNT_W        = 16,
    parameter int TILE_W       = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_w_beats,
    input  logic [CNT_W-1:0]  cfg_if_beats,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic              w_valid,
    input  logic              if_valid,
    output logic              ready,
    output logic              w_read,
    output logic              if_read,
    output logic              clr_w,
    output logic              clr_if,
    output logic              switch,
    output logic              first,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall
`endif
);

    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CLR, PRELOAD, SWAP, STREAM, DRAIN, DONE} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    w_beats, if_beats, w_cnt, if_cnt;
    logic [TILE_W-1:0]   tiles, tile;
    logic [DW-1:0]       drain_cnt;
    logic                err_q;
    logic                accept, cfg_zero, last_tile, w_beat, if_beat, w_fin, if_fin;

    assign accept    = start & ready;
    assign cfg_zero  = (cfg_w_beats == '0) | (cfg_if_beats == '0) | (cfg_tiles == '0);
    assign last_tile = tile == tiles - TILE_W'(1);
    assign w_beat    = w_read & w_valid;
    assign if_beat   = if_read & if_valid;
    // completion includes a beat landing this cycle so the request drops right after the final beat
    assign w_fin     = (w_cnt == w_beats) | (w_beat & (w_cnt + CNT_W'(1) == w_beats));
    assign if_fin    = (if_cnt == if_beats) | (if_beat & (if_cnt + CNT_W'(1) == if_beats));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept & ~cfg_zero) state_nx = CLR;
            CLR:     state_nx = PRELOAD;
            PRELOAD: if (w_fin) state_nx = SWAP;
            SWAP:    state_nx = STREAM;
            STREAM:  if (if_fin & (w_fin | last_tile))
                         state_nx = ~last_tile ? SWAP : (DRAIN_CYCLES == 0 ? DONE : DRAIN);
            DRAIN:   if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from registered state and counters only
    always_comb begin
        ready   = state == IDLE;
        busy    = ~ready;
        switch  = state == SWAP;
        clr_if  = switch;
        first   = switch & (tile == '0);
        last    = switch & last_tile;
        clr_w   = (state == CLR) | (switch & ~last_tile);
        w_read  = ((state == PRELOAD) | ((state == STREAM) & ~last_tile)) & (w_cnt != w_beats);
        if_read = (state == STREAM) & (if_cnt != if_beats);
        done    = state == DONE;
        err     = err_q;
    end

    // config latch, beat/tile/drain counters and reject pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_beats   <= '0;
            if_beats  <= '0;
            tiles     <= '0;
            w_cnt     <= '0;
            if_cnt    <= '0;
            tile      <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept & cfg_zero;
            if (accept) begin
                w_beats  <= cfg_w_beats;
                if_beats <= cfg_if_beats;
                tiles    <= cfg_tiles;
            end
            if (clr_w)       w_cnt <= '0;
            else if (w_beat) w_cnt <= w_cnt + CNT_W'(1);
            if (clr_if)       if_cnt <= '0;
            else if (if_beat) if_cnt <= if_cnt + CNT_W'(1);
            if (state == CLR)                                tile <= '0;
            else if ((state == STREAM) & (state_nx == SWAP)) tile <= tile + TILE_W'(1);
            drain_cnt <= state == DRAIN ? drain_cnt + DW'(1) : '0;
        end
    end

`ifdef CONV_CTRL_PERF_EN
    // saturating count of cycles a request waits on a source that has no beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall <= '0;
        else if (accept)
            perf_stall <= '0;
        else if ((((state == STREAM) & ((if_read & ~if_valid) | (w_read & ~w_valid))) |
                  ((state == PRELOAD) & w_read & ~w_valid)) & ~&perf_stall)
            perf_stall <= perf_stall + 32'd1;
    end
`endif

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// tb_conv_tile_ctrl: randomized and directed checks of conv_tile_ctrl against a sequential job model.
module tb_conv_tile_ctrl;
    localparam int CNT_W  = 16;
    localparam int TILE_W = 8;
    localparam int DRAIN  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [CNT_W-1:0]  cfg_w_beats = '0;
    logic [CNT_W-1:0]  cfg_if_beats = '0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic w_valid = 1'b0;
    logic if_valid = 1'b0;
    logic ready, w_read, if_read, clr_w, clr_if, switch, first, last, busy, done, err;
`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    conv_tile_ctrl #(.CNT_W(CNT_W), .TILE_W(TILE_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_w_beats(cfg_w_beats), .cfg_if_beats(cfg_if_beats), .cfg_tiles(cfg_tiles),
        .w_valid(w_valid), .if_valid(if_valid),
        .ready(ready), .w_read(w_read), .if_read(if_read), .clr_w(clr_w), .clr_if(clr_if),
        .switch(switch), .first(first), .last(last), .busy(busy), .done(done), .err(err)
`ifdef CONV_CTRL_PERF_EN
        , .perf_stall(perf_stall)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        chk(n, {31'b0, a}, {31'b0, e});
    endtask

    // ---------------- behavioural model: a job walked as a sequential program ----------------
    bit e_ready = 1'b1, e_wr, e_ir, e_cw, e_ci, e_sw, e_fi, e_la, e_dn, e_er;
    int m_perf = 0;
    bit s_start, s_wv, s_iv;
    int s_cw, s_ci, s_ct;

    task automatic set_exp(input bit rd, wr, ir, cw, ci, sw, fi, la, dn, er);
        e_ready = rd; e_wr = wr; e_ir = ir; e_cw = cw; e_ci = ci;
        e_sw = sw; e_fi = fi; e_la = la; e_dn = dn; e_er = er;
    endtask

    task automatic step(output bit ab);
        @(posedge clk or posedge rst);
        ab = rst;
        s_start = start; s_wv = w_valid; s_iv = if_valid;
        s_cw = int'(cfg_w_beats); s_ci = int'(cfg_if_beats); s_ct = int'(cfg_tiles);
    endtask

    task automatic run_model();
        bit ab, eb, lt;
        int wb, ib, tn, wc, ic;
        eb = 0;
        forever begin
            set_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, eb);
            step(ab); if (ab) return;
            eb = 0;
            if (!s_start) continue;
            m_perf = 0;
            wb = s_cw; ib = s_ci; tn = s_ct;
            if (wb == 0 || ib == 0 || tn == 0) begin eb = 1; continue; end
            set_exp(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            step(ab); if (ab) return;
            wc = 0;
            while (wc < wb) begin
                set_exp(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                step(ab); if (ab) return;
                if (s_wv) wc++; else m_perf++;
            end
            for (int t = 0; t < tn; t++) begin
                lt = (t == tn - 1);
                set_exp(0, 0, 0, !lt, 1, 1, t == 0, lt, 0, 0);
                step(ab); if (ab) return;
                ic = 0;
                wc = lt ? wb : 0;
                while (ic < ib || wc < wb) begin
                    set_exp(0, wc < wb, ic < ib, 0, 0, 0, 0, 0, 0, 0);
                    step(ab); if (ab) return;
                    if ((ic < ib && !s_iv) || (wc < wb && !s_wv)) m_perf++;
                    if (ic < ib && s_iv) ic++;
                    if (wc < wb && s_wv) wc++;
                end
            end
            repeat (DRAIN) begin
                set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                step(ab); if (ab) return;
            end
            set_exp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step(ab); if (ab) return;
        end
    endtask

    initial forever begin
        set_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_perf = 0;
        @(negedge rst);
        run_model();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk1("ready", ready, e_ready);
        chk1("busy", busy, !e_ready);
        chk1("w_read", w_read, e_wr);
        chk1("if_read", if_read, e_ir);
        chk1("clr_w", clr_w, e_cw);
        chk1("clr_if", clr_if, e_ci);
        chk1("switch", switch, e_sw);
        chk1("first", first, e_fi);
        chk1("last", last, e_la);
        chk1("done", done, e_dn);
        chk1("err", err, e_er);
`ifdef CONV_CTRL_PERF_EN
        chk("perf_stall", perf_stall, m_perf);
`endif
    end

    // ---------------- event monitor for hand-computed expectations ----------------
    int sw_q[$];
    logic [2:0] flg_q[$];
    int done_n = 0, done_cyc = 0, err_n = 0, err_cyc = 0;
    int wbeat_n = 0, ibeat_n = 0, wr_n = 0, clr_n = 0, nr_n = 0;
    always @(negedge clk) begin
        if (switch) begin sw_q.push_back(cyc); flg_q.push_back({first, last, clr_w}); end
        if (done) begin done_n++; done_cyc = cyc; end
        if (err) begin err_n++; err_cyc = cyc; end
        if (w_read && w_valid) wbeat_n++;
        if (if_read && if_valid) ibeat_n++;
        if (w_read) wr_n++;
        if (clr_w || clr_if) clr_n++;
        if (!ready) nr_n++;
    end

    // ---------------- stimulus ----------------
    bit rand_v = 0;
    int t0, b_sw, b_done, b_err, b_wb, b_ib, b_wr, b_clr, b_nr;

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_v) begin
            w_valid = ($urandom_range(0, 9) < 7);
            if_valid = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic do_start(input int w, input int i, input int t);
        tick();
        cfg_w_beats = CNT_W'(w); cfg_if_beats = CNT_W'(i); cfg_tiles = TILE_W'(t);
        start = 1'b1;
        t0 = cyc;
        b_sw = sw_q.size(); b_done = done_n; b_err = err_n; b_wb = wbeat_n; b_ib = ibeat_n;
        b_wr = wr_n; b_clr = clr_n; b_nr = nr_n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string n);
        int k = 0;
        while (done_n == b_done && k < 2000) begin tick(); k++; end
        chk(n, {31'b0, done_n != b_done}, 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk1("reset_ready", ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        w_valid = 1'b1; if_valid = 1'b1;
        repeat (2) tick();

        // nominal two-tile job
        do_start(3, 4, 2);
        wait_done("nom_done_seen");
        chk("nom_ready_cycle", cyc - t0, 20);
        chk1("nom_ready_after_done", ready, 1'b1);
        chk("nom_done_cycle", done_cyc - t0, 19);
        chk("nom_switches", sw_q.size() - b_sw, 2);
        chk("nom_sw0_cycle", sw_q[b_sw] - t0, 5);
        chk("nom_sw1_cycle", sw_q[b_sw + 1] - t0, 10);
        chk("nom_sw0_flags", {29'b0, flg_q[b_sw]}, 32'b101);
        chk("nom_sw1_flags", {29'b0, flg_q[b_sw + 1]}, 32'b010);
        chk("nom_wbeats", wbeat_n - b_wb, 6);
        chk("nom_ibeats", ibeat_n - b_ib, 8);

        // single tile
        do_start(3, 5, 1);
        wait_done("single_done_seen");
        chk("single_done_cycle", done_cyc - t0, 15);
        chk("single_sw_flags", {29'b0, flg_q[b_sw]}, 32'b110);
        chk("single_wread_cycles", wr_n - b_wr, 3);

        // zero config rejected
        do_start(3, 0, 2);
        repeat (4) tick();
        chk("zero_err_count", err_n - b_err, 1);
        chk("zero_err_cycle", err_cyc - t0, 1);
        chk("zero_no_switch", sw_q.size() - b_sw, 0);
        chk("zero_no_read", wr_n - b_wr, 0);
        chk("zero_no_clear", clr_n - b_clr, 0);
        chk("zero_ready_held", nr_n - b_nr, 0);

        // weight stall during STREAM
        do_start(8, 3, 2);
        repeat (11) tick();
        w_valid = 1'b0;
        repeat (5) tick();
        w_valid = 1'b1;
        wait_done("stall_done_seen");
        chk("stall_sw0_cycle", sw_q[b_sw] - t0, 10);
        chk("stall_tile_period", sw_q[b_sw + 1] - sw_q[b_sw], 14);
        chk("stall_wbeats", wbeat_n - b_wb, 16);
`ifdef CONV_CTRL_PERF_EN
        chk("stall_perf", perf_stall, 5);
`endif

        // reset mid-STREAM, then a normal job
        do_start(3, 4, 2);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk1("abort_ready", ready, 1'b1);
        chk1("abort_if_read", if_read, 1'b0);
        chk1("abort_w_read", w_read, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("abort_no_done", done_n - b_done, 0);
        do_start(3, 4, 2);
        wait_done("after_abort_done_seen");
        chk("after_abort_done_cycle", done_cyc - t0, 19);

        // start while busy is ignored
        do_start(3, 4, 2);
        repeat (15) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_done_seen");
        repeat (10) tick();
        chk("busy_single_done", done_n - b_done, 1);
        chk("busy_switches", sw_q.size() - b_sw, 2);

        // randomized jobs with random valids
        rand_v = 1;
        for (int j = 0; j < 40; j++) begin
            int w, i, t, k;
            repeat ($urandom_range(0, 3)) tick();
            w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            i = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            t = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            do_start(w, i, t);
            if (j % 5 == 0) begin
                repeat (3) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            k = 0;
            while (!ready && k < 600) begin tick(); k++; end
            chk1("rand_job_ends", ready, 1'b1);
        end
        rand_v = 0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end
endmodule
